mesi_snoop_bus: RTL

- Parametrised MESI snooping-coherence controller for NUM_CORES private caches of NUM_LINES lines each, sharing one snoop bus.
- Holds the per-core, per-line MESI state arrays and arbitrates core requests round-robin.
- Serialises one bus transaction at a time; issues BusRd/BusRdX/BusUpgr; applies requester and snooper state transitions, including M-line flush signalling.
- Successor to the two-core, single-line MESI state machine; sits between the core request ports and the shared memory bus.

---
 rtl/mesi_pkg.sv | 45 ++++
 rtl/mesi_snoop_bus_if.sv | 34 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mesi_snoop_bus.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mesi_pkg.sv
// Shared MESI encodings, snoop-bus commands, controller FSM states and the
// snooper transition helper used by the snoop-bus controller.
package mesi_pkg;

  localparam logic [2:0] MesiI = 3'b001;
  localparam logic [2:0] MesiS = 3'b010;
  localparam logic [2:0] MesiM = 3'b011;
  localparam logic [2:0] MesiE = 3'b100;

  localparam logic [2:0] CmdNone    = 3'b000;
  localparam logic [2:0] CmdBusRd   = 3'b001;
  localparam logic [2:0] CmdBusRdX  = 3'b010;
  localparam logic [2:0] CmdBusUpgr = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StSnoop,
    StDone
  } fsm_e;

  // Any code outside the four legal states is treated as Invalid.
  function automatic logic [2:0] sanitize_state(input logic [2:0] st);
    logic [2:0] res;
    case (st)
      MesiS, MesiM, MesiE: res = st;
      default:             res = MesiI;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] next_snoop_state(input logic [2:0] st, input logic [2:0] cmd);
    logic [2:0] s;
    logic [2:0] res;
    s   = sanitize_state(st);
    res = s;
    case (cmd)
      CmdBusRd:   if (s == MesiM || s == MesiE) res = MesiS;
      CmdBusRdX:  res = MesiI;
      CmdBusUpgr: if (s == MesiS) res = MesiI;
      default:    res = s;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mesi_snoop_bus_if.sv
// Core request, snoop-bus and state-readback signals of the MESI controller.
interface mesi_snoop_bus_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NUM_LINES = 8
);
  localparam int unsigned LINE_W  = $clog2(NUM_LINES);
  localparam int unsigned OWNER_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]        req_valid;
  logic [NUM_CORES-1:0]        req_write;
  logic [NUM_CORES*LINE_W-1:0] req_line;
  logic [NUM_CORES-1:0]        req_ack;
  logic                        req_hit;
  logic [2:0]                  bus_cmd;
  logic [OWNER_W-1:0]          bus_owner;
  logic [LINE_W-1:0]           bus_line;
  logic                        flush;
  logic [OWNER_W-1:0]          flush_core;
  logic                        busy;
  logic [OWNER_W-1:0]          dbg_core;
  logic [LINE_W-1:0]           dbg_line;
  logic [2:0]                  dbg_state;

  modport master (
    output req_valid, req_write, req_line, dbg_core, dbg_line,
    input  req_ack, req_hit, bus_cmd, bus_owner, bus_line, flush, flush_core, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_write, req_line, dbg_core, dbg_line,
    output req_ack, req_hit, bus_cmd, bus_owner, bus_line, flush, flush_core, busy, dbg_state
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]                            req_i,
  input  logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] ptr_i,
  output logic [NUM_CORES-1:0]                            gnt_o,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] idx_o,
  output logic                                            valid_o
);
  localparam int unsigned OWNER_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Two passes over constant indices: upper window first, then the wrap-around.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!valid_o && req_i[i] && (OWNER_W'(i) >= ptr_i)) begin
        valid_o  = 1'b1;
        idx_o    = OWNER_W'(i);
        gnt_o[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!valid_o && req_i[i]) begin
        valid_o  = 1'b1;
        idx_o    = OWNER_W'(i);
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesi_snoop_bus.sv
// MESI snooping-coherence controller: per-core line state arrays, round-robin
// grant and one serialised three-cycle bus transaction at a time.
module mesi_snoop_bus
  import mesi_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NUM_LINES = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  mesi_snoop_bus_if.slave bus
);
  localparam int unsigned LINE_W  = $clog2(NUM_LINES);
  localparam int unsigned OWNER_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  fsm_e               state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               write_q, write_d;
  logic               hit_q, hit_d;
  logic [2:0]         mesi_q [NUM_CORES][NUM_LINES];
  logic [2:0]         mesi_d [NUM_CORES][NUM_LINES];

  logic [NUM_CORES-1:0] gnt;
  logic [OWNER_W-1:0]   gnt_idx;
  logic                 gnt_valid;

  logic [2:0]         own_st;
  logic [2:0]         snp_st;
  logic [2:0]         snoop_cmd;
  logic               snoop_hit;
  logic               shared;
  logic               flush_hit;
  logic [OWNER_W-1:0] flush_idx;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES)
  ) u_arb (
    .req_i  (bus.req_valid),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .valid_o(gnt_valid)
  );

  // Requester classification and snooper scan for the latched transaction.
  always_comb begin
    own_st    = sanitize_state(mesi_q[owner_q][line_q]);
    snp_st    = MesiI;
    snoop_cmd = CmdNone;
    snoop_hit = 1'b0;
    shared    = 1'b0;
    flush_hit = 1'b0;
    flush_idx = '0;
    if (write_q) begin
      if (own_st == MesiM || own_st == MesiE) snoop_hit = 1'b1;
      else if (own_st == MesiS)               snoop_cmd = CmdBusUpgr;
      else                                    snoop_cmd = CmdBusRdX;
    end else begin
      if (own_st != MesiI) snoop_hit = 1'b1;
      else                 snoop_cmd = CmdBusRd;
    end
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      if (OWNER_W'(c) != owner_q) begin
        snp_st = sanitize_state(mesi_q[c][line_q]);
        if (snp_st != MesiI) shared = 1'b1;
        if (snp_st == MesiM && !flush_hit) begin
          flush_hit = 1'b1;
          flush_idx = OWNER_W'(c);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    line_d   = line_q;
    write_d  = write_q;
    hit_d    = hit_q;
    mesi_d   = mesi_q;

    bus.req_ack    = '0;
    bus.req_hit    = 1'b0;
    bus.bus_cmd    = CmdNone;
    bus.bus_owner  = '0;
    bus.bus_line   = '0;
    bus.flush      = 1'b0;
    bus.flush_core = '0;
    bus.busy       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          write_d = |(gnt & bus.req_write);
          for (int unsigned c = 0; c < NUM_CORES; c++) begin
            if (gnt[c]) line_d = bus.req_line[c*LINE_W +: LINE_W];
          end
          state_d = StSnoop;
        end
      end
      StSnoop: begin
        bus.busy      = 1'b1;
        bus.bus_cmd   = snoop_cmd;
        bus.bus_owner = owner_q;
        bus.bus_line  = line_q;
        if (flush_hit && snoop_cmd != CmdNone) begin
          bus.flush      = 1'b1;
          bus.flush_core = flush_idx;
        end
        hit_d = snoop_hit;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
          if (OWNER_W'(c) != owner_q) begin
            mesi_d[c][line_q] = next_snoop_state(mesi_q[c][line_q], snoop_cmd);
          end
        end
        if (write_q)        mesi_d[owner_q][line_q] = MesiM;
        else if (snoop_hit) mesi_d[owner_q][line_q] = own_st;
        else                mesi_d[owner_q][line_q] = shared ? MesiS : MesiE;
        state_d = StDone;
      end
      StDone: begin
        bus.busy             = 1'b1;
        bus.req_ack[owner_q] = 1'b1;
        bus.req_hit          = hit_q;
        bus.bus_owner        = owner_q;
        bus.bus_line         = line_q;
        rr_ptr_d = (owner_q == OWNER_W'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.dbg_state = sanitize_state(mesi_q[bus.dbg_core][bus.dbg_line]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      line_q   <= '0;
      write_q  <= 1'b0;
      hit_q    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
          mesi_q[c][l] <= MesiI;
        end
      end
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      line_q   <= line_d;
      write_q  <= write_d;
      hit_q    <= hit_d;
      mesi_q   <= mesi_d;
    end
  end

endmodule
